piso_shift_tx: RTL
==================

Name: piso_shift_tx

Overview:
- Parallel-in/serial-out transmit register. It is the sending end of the register-level serial link, and the counterpart of the team's serial-in/parallel-out capture register.
- Accepts one WIDTH-bit word over a valid/ready load handshake, then shifts it out one bit per accepted serial beat.
- Flags the final bit of each word. Supports back-to-back words with no idle cycle.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  producer presents load_data.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  parallel word to transmit.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out holds a valid bit.
- ser_last  output  1  ser_out is the final bit of the word.
- ser_ready  input  1  consumer accepts the current bit this cycle.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE; shift register=0; bit counter=0; ser_out=0; ser_valid=0; ser_last=0.
- load_ready is combinational and is 0 while rst=1.
- States:
  - IDLE: ser_valid=0. load_ready=1.
  - SHIFT: ser_valid=1.
- Load accept: occurs when load_valid and load_ready are both high at the rising edge.
  - On accept, the shift register captures load_data and the counter is set to 0.
  - The next state is SHIFT.
- Latency: a word accepted in cycle N presents its first bit on ser_out in cycle N+1.
- Beat accept: occurs when ser_valid and ser_ready are both high at the rising edge.
  - On a beat, the register shifts by one position: toward MSB when MSB_FIRST=1, toward LSB when MSB_FIRST=0. Zero fills the vacated bit.
  - The counter increments on each beat.
- ser_out is shift_reg[WIDTH-1] when MSB_FIRST=1, otherwise shift_reg[0]. It is a direct register tap, with no combinational path from load_data.
- ser_last = ser_valid AND (counter == WIDTH-1).
- Backpressure: while ser_valid=1 and ser_ready=0, ser_out, ser_last, the counter and the register hold steady. There is no timeout.
- load_ready = (state==IDLE) OR (state==SHIFT AND ser_last AND ser_ready).
- End of word: a last-bit beat with no simultaneous load returns the block to IDLE. The counter goes to 0.
- Simultaneous last-bit beat and load: the new word is captured and the state stays SHIFT. The new word's first bit appears the next cycle, giving exactly WIDTH beats per word with no gap.
- Loads are ignored in SHIFT unless ser_last AND ser_ready. load_ready=0 enforces this; the producer must hold load_data stable until accepted.
- Counter width is clog2(WIDTH). It never exceeds WIDTH-1 and wraps only by explicit reload.
- Reset mid-word: the partial word is discarded. ser_valid drops to 0 in the cycle after the reset edge, and no ser_last is produced for the aborted word.
- While ser_valid=0, ser_out is held at 0.

Decomposition:
- Shared package (register_pkg):
  - state encoding constants ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - a clog2 function for counter width;
  - default WIDTH constant REG_WIDTH=8.
- The SIPO receiver uses the same package.
- One natural sub-module, piso_bit_counter: a modulo-WIDTH up-counter with sync clear, load-zero and enable. It outputs the count and an is_last flag.
- The shift register and FSM stay in the top level.

Test Plan:
- Reset: with rst=1 for 2 cycles, all outputs are 0 and load_ready=0. After release, load_ready=1 and ser_valid=0.
- Single word, WIDTH=8, MSB_FIRST=1, ser_ready=1: load 8'hA5 in cycle 0. Cycles 1..8 output 1,0,1,0,0,1,0,1. ser_last=1 only in cycle 8. Cycle 9: ser_valid=0, load_ready=1.
- LSB-first, MSB_FIRST=0: load 8'h0F. Output is 1,1,1,1,0,0,0,0, with ser_last on the 8th bit.
- Backpressure: load 8'hC3 and drop ser_ready for 3 cycles after bit 2. ser_out and ser_last stay frozen for those cycles. The full stream is still 1,1,0,0,0,0,1,1 over 11 cycles.
- Back-to-back: hold load_valid=1 with 8'hFF then 8'h00. Sixteen contiguous valid beats come out: eight 1s then eight 0s. ser_last is seen in beats 8 and 16, and ser_valid never drops between words.
- Reset mid-word: load 8'h81 and assert rst after 3 beats. ser_valid=0 next cycle and no ser_last appears. A fresh load of 8'h01 then transmits 0,0,0,0,0,0,0,1 correctly.

Source files
------------

// File: rtl/register_pkg.sv
// Shared definitions for the register-level serial link (PISO transmitter
// and SIPO capture register).
//   - state_e   : two-state encoding used by the link FSMs
//   - REG_WIDTH : default word length
//   - clog2_f   : ceiling log2, used to size bit counters
package register_pkg;

    localparam int REG_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Ceiling log2 for word lengths up to 2**31.
    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if (int'(32'd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/piso_shift_tx_if.sv
// Load handshake and serial beat bundle of the PISO transmitter.
//   load_valid / load_ready / load_data : parallel word handshake (producer -> tx)
//   ser_out / ser_valid / ser_last      : serial bit stream (tx -> consumer)
//   ser_ready                           : consumer accepts current bit
// Modports: slave = transmitter side, master = producer/consumer side.
interface piso_shift_tx_if
    import register_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
) ();

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             ser_ready;

    modport slave (
        input  load_valid,
        input  load_data,
        input  ser_ready,
        output load_ready,
        output ser_out,
        output ser_valid,
        output ser_last
    );

    modport master (
        output load_valid,
        output load_data,
        output ser_ready,
        input  load_ready,
        input  ser_out,
        input  ser_valid,
        input  ser_last
    );

endinterface

// File: rtl/piso_bit_counter.sv
// Modulo-WIDTH bit position counter for the PISO transmitter.
//   clk, rst  : clock and synchronous active-high reset
//   clr       : synchronous clear
//   load_zero : restart at bit 0 (new word accepted)
//   en        : advance one position (serial beat accepted)
//   count     : current bit position, 0..WIDTH-1
//   is_last   : count == WIDTH-1
module piso_bit_counter
    import register_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH,
    localparam int CW = clog2_f(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load_zero,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          is_last
);

    localparam logic [CW-1:0] LAST_C = CW'(WIDTH - 1);

    logic [CW-1:0] count_r;

    // Bit position: clear/load-zero win over advance; wraps at WIDTH-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (clr || load_zero) begin
            count_r <= '0;
        end else if (en) begin
            if (count_r == LAST_C) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + CW'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign count   = count_r;
    assign is_last = (count_r == LAST_C);

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmit register.
// Accepts a WIDTH-bit word over load_valid/load_ready and shifts it out one
// bit per accepted serial beat, flagging the final bit with ser_last. A new
// word may be accepted on the last-bit beat, giving gap-free back-to-back words.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : piso_shift_tx_if.slave (load handshake + serial stream)
// Parameters: WIDTH (2..32), MSB_FIRST (1 = bit WIDTH-1 first).
module piso_shift_tx
    import register_pkg::*;
#(
    parameter int WIDTH     = REG_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    piso_shift_tx_if.slave    bus
);

    localparam int CW = clog2_f(WIDTH);
    localparam logic [CW-1:0] LAST_C = CW'(WIDTH - 1);

    state_e           state_r;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_nxt_s;
    logic [CW-1:0]    count_s;
    logic             is_last_s;
    logic             ser_valid_s;
    logic             ser_last_s;
    logic             load_ready_s;
    logic             load_s;
    logic             beat_s;

    assign ser_valid_s = (state_r == ST_SHIFT);
    assign ser_last_s  = ser_valid_s && (count_s == LAST_C);
    assign load_s      = bus.load_valid && load_ready_s;
    assign beat_s      = ser_valid_s && bus.ser_ready;

    // Load acceptance: always in IDLE, or on the last-bit beat of a word.
    always_comb begin
        load_ready_s = 1'b0;
        if (rst) begin
            load_ready_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            load_ready_s = 1'b1;
        end else if (ser_last_s && bus.ser_ready) begin
            load_ready_s = 1'b1;
        end else begin
            load_ready_s = 1'b0;
        end
    end

    // Next shift value: move toward the tap end, zero-fill the vacated bit so
    // the register drains to zero and ser_out rests at 0 once idle.
    always_comb begin
        shift_nxt_s = shift_r;
        if (MSB_FIRST) begin
            shift_nxt_s = {shift_r[WIDTH-2:0], 1'b0};
        end else begin
            shift_nxt_s = {1'b0, shift_r[WIDTH-1:1]};
        end
    end

    // FSM and shift register; a load on the last beat overrides the drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            shift_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_s) begin
                        shift_r <= bus.load_data;
                        state_r <= ST_SHIFT;
                    end else begin
                        shift_r <= shift_r;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (load_s) begin
                        shift_r <= bus.load_data;
                        state_r <= ST_SHIFT;
                    end else if (beat_s) begin
                        shift_r <= shift_nxt_s;
                        state_r <= is_last_s ? ST_IDLE : ST_SHIFT;
                    end else begin
                        shift_r <= shift_r;
                        state_r <= ST_SHIFT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    shift_r <= '0;
                end
            endcase
        end
    end

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk       (clk),
        .rst       (rst),
        .clr       (1'b0),
        .load_zero (load_s),
        .en        (beat_s && !load_s),
        .count     (count_s),
        .is_last   (is_last_s)
    );

    assign bus.load_ready = load_ready_s;
    assign bus.ser_out    = MSB_FIRST ? shift_r[WIDTH-1] : shift_r[0];
    assign bus.ser_valid  = ser_valid_s;
    assign bus.ser_last   = ser_last_s;

endmodule
